ram_bank: RTL and testbench



---
 rtl/ram_bank_pkg.sv | 19 +
 rtl/ram_word.sv | 20 ++
 rtl/ram_bank.sv | 159 +++++++++++++++
 tb/tb_ram_bank.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ram_bank_pkg.sv
// Shared types and helpers for the ram_bank scratch/operand store.
// Parity option (RAM_PARITY_EN) is resolved in ram_bank.sv; this package is option-independent.
package ram_bank_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_DEPTH  = 4;
    localparam int unsigned DEFAULT_ADDR_W = 8;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    // Depth need not be a power of two, so range is a magnitude compare, not an MSB test.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/ram_word.sv
// One storage word of ram_bank (data plus optional parity bit when RAM_PARITY_EN is defined).
module ram_word #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_bank.sv
// Single-port RAM bank with registered read, range error, and hardware clear-all sequence.
// Define RAM_PARITY_EN to store and check a per-word even-parity bit.
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr,
    input  logic              par_inj,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              err,
    output logic              busy,
    output logic              parity_err
);

`ifdef RAM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif
    localparam int unsigned CNT_W = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clearing;
    logic               acc;
    logic               in_range;
    logic [DEPTH-1:0]   word_we;
    logic [DATA_W-1:0]  wdata_raw;
    logic [WORD_W-1:0]  wdata;
    logic [WORD_W-1:0]  rword;
    logic [WORD_W-1:0]  word_q [DEPTH];

    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               rd_valid_q, rd_valid_d;
    logic               err_q, err_d;
    logic               perr_q, perr_d;

    assign clearing = (state_q == StClear);
    assign acc      = cs & ~clearing & ~clr;
    assign in_range = addr_in_range(32'(addr), DEPTH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // During clear the counter owns the write port; host accesses are locked out.
    always_comb begin
        word_we = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (clearing) begin
                word_we[i] = (cnt_q == CNT_W'(i));
            end else begin
                word_we[i] = acc & rw & (addr == ADDR_W'(i));
            end
        end
    end

    assign wdata_raw = clearing ? '0 : data_in;
`ifdef RAM_PARITY_EN
    assign wdata = {(^wdata_raw) ^ (par_inj & ~clearing), wdata_raw};
`else
    assign wdata = wdata_raw;
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
`endif

    always_comb begin
        rword = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                rword = word_q[i];
            end
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        perr_d     = 1'b0;
        if (acc) begin
            err_d = ~in_range;
            if (!rw) begin
                rd_valid_d = 1'b1;
                data_out_d = in_range ? rword[DATA_W-1:0] : '0;
`ifdef RAM_PARITY_EN
                perr_d     = in_range & ((^rword[DATA_W-1:0]) != rword[DATA_W]);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            perr_q     <= perr_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        ram_word #(
            .W(WORD_W)
        ) u_word (
            .clk(clk),
            .rst(rst),
            .we (word_we[i]),
            .d  (wdata),
            .q  (word_q[i])
        );
    end

    assign data_out   = data_out_q;
    assign rd_valid   = rd_valid_q;
    assign err        = err_q;
    assign busy       = clearing;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_ram_bank.sv
// Directed, table-driven bench for ram_bank (DATA_W=8, DEPTH=4, ADDR_W=8).
// Expected parity_err follows RAM_PARITY_EN as defined for the build.
module tb_ram_bank;

`ifdef RAM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, cs, rw, clr, par_inj;
    logic [7:0] addr, data_in;
    logic [7:0] data_out;
    logic       rd_valid, err, busy, parity_err;

    always #5 clk = ~clk;

    ram_bank #(
        .DATA_W(8),
        .DEPTH (4),
        .ADDR_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .rw        (rw),
        .addr      (addr),
        .data_in   (data_in),
        .clr       (clr),
        .par_inj   (par_inj),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .err       (err),
        .busy      (busy),
        .parity_err(parity_err)
    );

    typedef struct {
        logic       rst, cs, rw;
        logic [7:0] addr, din;
        logic       clr, inj;
        logic [7:0] dout;
        logic       valid, err, busy, perr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic c, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic cl, input logic inj,
                       input logic [7:0] ed, input logic ev, input logic ee,
                       input logic eb, input logic ep);
        vec_t v;
        v.rst = r; v.cs = c; v.rw = w; v.addr = a; v.din = d; v.clr = cl; v.inj = inj;
        v.dout = ed; v.valid = ev; v.err = ee; v.busy = eb; v.perr = ep;
        vecs.push_back(v);
    endtask

    task automatic chk(input int idx, input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %h, want %h", idx, name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rst = v.rst; cs = v.cs; rw = v.rw; addr = v.addr; data_in = v.din;
        clr = v.clr; par_inj = v.inj;
        @(posedge clk);
        #1;
        n_vec++;
        chk(idx, "data_out", data_out, v.dout);
        chk(idx, "rd_valid", 8'(rd_valid), 8'(v.valid));
        chk(idx, "err", 8'(err), 8'(v.err));
        chk(idx, "busy", 8'(busy), 8'(v.busy));
        chk(idx, "parity_err", 8'(parity_err), 8'(v.perr));
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1; cs = 1'b0; rw = 1'b0; addr = '0; data_in = '0; clr = 1'b0; par_inj = 1'b0;

        //  rst cs rw addr  din  clr inj   dout  v  e  b  p
        add(1, 0, 0, 8'd0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) add(0, 1, 0, 8'(a), 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 1, 1, 8'd2, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 8'd2, 8'h00, 0, 0, 8'hA5, 1, 0, 0, 0);
        add(0, 1, 0, 8'd1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 0, 1, 8'd0, 8'hEE, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 8'd7, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 1, 1, 8'd5, 8'hFF, 0, 0, 8'h00, 0, 1, 0, 0);
        add(0, 1, 0, 8'd0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 1, 0, 8'd1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 1, 0, 8'd2, 8'h00, 0, 0, 8'hA5, 1, 0, 0, 0);
        add(0, 1, 0, 8'd3, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
        // Fill, then clear with a colliding write that must be dropped.
        for (int a = 0; a < 4; a++) add(0, 1, 1, 8'(a), 8'(8'h11 * (a + 1)), 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 8'd3, 8'h00, 0, 0, 8'h44, 1, 0, 0, 0);
        add(0, 1, 1, 8'd0, 8'h99, 1, 0, 8'h44, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 8'd0, 8'h00, 1, 0, 8'h44, 0, 0, 1, 0);
        add(0, 1, 0, 8'd0, 8'h00, 1, 0, 8'h44, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) add(0, 1, 0, 8'(a), 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
        // Reset landing in the middle of a clear.
        add(0, 1, 1, 8'd1, 8'h55, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 1, 8'd3, 8'h66, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 8'd1, 8'h00, 0, 0, 8'h55, 1, 0, 0, 0);
        add(0, 0, 0, 8'd0, 8'h00, 1, 0, 8'h55, 0, 0, 1, 0);
        add(0, 0, 0, 8'd0, 8'h00, 0, 0, 8'h55, 0, 0, 1, 0);
        add(1, 1, 0, 8'd3, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 8'd3, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 1, 0, 8'd1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
        // Parity injection, repair by rewrite, and repair by clear.
        add(0, 1, 1, 8'd1, 8'h3C, 0, 1, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 8'd1, 8'h00, 0, 0, 8'h3C, 1, 0, 0, PAR);
        add(0, 1, 0, 8'd2, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 1, 1, 8'd1, 8'h3C, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 8'd1, 8'h00, 0, 0, 8'h3C, 1, 0, 0, 0);
        add(0, 1, 1, 8'd0, 8'h81, 0, 1, 8'h3C, 0, 0, 0, 0);
        add(0, 0, 0, 8'd0, 8'h00, 1, 0, 8'h3C, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 8'd0, 8'h00, 0, 0, 8'h3C, 0, 0, 1, 0);
        add(0, 0, 0, 8'd0, 8'h00, 0, 0, 8'h3C, 0, 0, 0, 0);
        add(0, 1, 0, 8'd0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Busy width measured independently of the table, with a bounded wait.
        @(negedge clk);
        cs = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        n_vec++;
        if (busy_cnt != 4) begin
            n_bad++;
            $display("FAIL busy_width: got %0d cycles, want 4", busy_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
